bs_host_ctrl: RTL and testbench

Host-side controller that drives the Black-Scholes processor's cmd/status interface.
- Accepts one job (constK, const1..3) over a valid/ready request port.
- Presents the constants to the processor, issues RUN, waits for COMPLETE, captures dout, issues ACK, and returns the result over a valid/ready response port.
- Guards against a hung processor with a cycle timeout.

---
 rtl/bs_host_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_bs_host_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_host_ctrl.sv
// Host-side controller for the Black-Scholes processor cmd/status port.
// Takes one job over a valid/ready request, drives the processor through
// RUN / COMPLETE / ACK, and returns the captured result or a timeout flag
// over a valid/ready response.
module bs_host_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_constK,
  input  logic [31:0]      req_const1,
  input  logic [31:0]      req_const2,
  input  logic [31:0]      req_const3,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_timeout,
  output logic [31:0]      p_constK,
  output logic [31:0]      p_const1,
  output logic [31:0]      p_const2,
  output logic [31:0]      p_const3,
  output logic [3:0]       p_cmd,
  input  logic [3:0]       p_status,
  input  logic [31:0]      p_dout,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_WAIT, S_ACK, S_RESP
  } state_e;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_RUN = 4'd1;
  localparam logic [3:0] CMD_ACK = 4'd2;
  localparam logic [3:0] PS_IDLE     = 4'd0;
  localparam logic [3:0] PS_COMPLETE = 4'd2;

  // Last counter value at which a job may still complete.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] job_q, job_d;
  logic [31:0]      constk_q, constk_d;
  logic [31:0]      const1_q, const1_d;
  logic [31:0]      const2_q, const2_d;
  logic [31:0]      const3_q, const3_d;
  logic [31:0]      data_q, data_d;
  logic             tout_q, tout_d;

  logic status_idle;
  logic status_complete;
  logic tmo_expired;

  // Anything other than the two decoded codes counts as "busy elsewhere".
  assign status_idle     = (p_status == PS_IDLE);
  assign status_complete = (p_status == PS_COMPLETE);
  assign tmo_expired     = (tmo_q >= TMO_LAST);

  // State, counters and datapath registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      job_q    <= '0;
      constk_q <= '0;
      const1_q <= '0;
      const2_q <= '0;
      const3_q <= '0;
      data_q   <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      job_q    <= job_d;
      constk_q <= constk_d;
      const1_q <= const1_d;
      const2_q <= const2_d;
      const3_q <= const3_d;
      data_q   <= data_d;
      tout_q   <= tout_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    job_d    = job_q;
    constk_d = constk_q;
    const1_d = const1_q;
    const2_d = const2_q;
    const3_d = const3_q;
    data_d   = data_q;
    tout_d   = tout_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          constk_d = req_constK;
          const1_d = req_const1;
          const2_d = req_const2;
          const3_d = req_const3;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        // Hold off until a previous (possibly aborted) run has drained.
        if (status_idle) begin
          tmo_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        tmo_d = tmo_q + 1'b1;
        if (status_complete) begin
          state_d = S_WAIT;
        end else if (tmo_expired) begin
          data_d  = '0;
          tout_d  = 1'b1;
          state_d = S_RESP;
        end else if (!status_idle) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // Completion takes priority over a simultaneous expiry; dout is
        // captured now because the processor re-samples once back in idle.
        if (status_complete) begin
          data_d  = p_dout;
          tout_d  = 1'b0;
          state_d = S_ACK;
        end else if (tmo_expired) begin
          data_d  = '0;
          tout_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_ACK: begin
        if (status_idle) begin
          job_d   = job_q + 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    p_cmd     = CMD_NOP;
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RUN:   p_cmd     = CMD_RUN;
      S_ACK:   p_cmd     = CMD_ACK;
      S_RESP:  rsp_valid = 1'b1;
      default: p_cmd     = CMD_NOP;
    endcase
  end

  assign p_constK    = constk_q;
  assign p_const1    = const1_q;
  assign p_const2    = const2_q;
  assign p_const3    = const3_q;
  assign rsp_data    = data_q;
  assign rsp_timeout = tout_q;
  assign job_count   = job_q;

endmodule

// File: tb/tb_bs_host_ctrl.sv
// Self-checking bench for bs_host_ctrl with a behavioural processor model.
module tb_bs_host_ctrl;
  localparam int TMO = 16;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          nreset;
  logic          req_valid, req_ready;
  logic [31:0]   req_constK, req_const1, req_const2, req_const3;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0]   rsp_data;
  logic [31:0]   p_constK, p_const1, p_const2, p_const3;
  logic [3:0]    p_cmd, p_status;
  logic [31:0]   p_dout;
  logic          busy;
  logic [CW-1:0] job_count;

  int n_checks = 0;
  int n_errs   = 0;
  int exp_jobs = 0;

  always #5 clk = ~clk;

  bs_host_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_constK(req_constK), .req_const1(req_const1),
    .req_const2(req_const2), .req_const3(req_const3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .p_constK(p_constK), .p_const1(p_const1),
    .p_const2(p_const2), .p_const3(p_const3),
    .p_cmd(p_cmd), .p_status(p_status), .p_dout(p_dout),
    .busy(busy), .job_count(job_count)
  );

  // ---------------- processor model ----------------
  // 0 IDLE, 1 RUNNING, 2 COMPLETE. Samples constants when it accepts RUN,
  // completes pm_lat cycles later unless hung, returns to IDLE on ACK.
  logic [3:0]  pm_st;
  int          pm_cnt;
  int          pm_lat   = 5;
  bit          pm_hang  = 0;
  bit          pm_mix   = 0;
  int          force_req = 0;   // 1: force COMPLETE, 2: force IDLE
  logic [31:0] pm_res, pm_junk;
  logic [31:0] pm_sK, pm_s1, pm_s2, pm_s3;

  function automatic logic [31:0] pfun(input logic [31:0] k, c1, c2, c3,
                                       input bit mix);
    return mix ? ((k ^ c1) + c3) : c2;
  endfunction

  always @(posedge clk) pm_junk <= $urandom;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pm_st  <= 4'd0;
      pm_cnt <= 0;
      pm_res <= '0;
      pm_sK <= '0; pm_s1 <= '0; pm_s2 <= '0; pm_s3 <= '0;
    end else if (force_req == 1) begin
      pm_st  <= 4'd2;
      pm_res <= 32'hBAD0_0001;
    end else if (force_req == 2) begin
      pm_st <= 4'd0;
    end else begin
      case (pm_st)
        4'd0: if (p_cmd == 4'd1) begin
          pm_st  <= 4'd1;
          pm_cnt <= pm_lat;
          pm_sK <= p_constK; pm_s1 <= p_const1;
          pm_s2 <= p_const2; pm_s3 <= p_const3;
          pm_res <= pfun(p_constK, p_const1, p_const2, p_const3, pm_mix);
        end
        4'd1: if (!pm_hang) begin
          if (pm_cnt <= 1) pm_st <= 4'd2;
          else             pm_cnt <= pm_cnt - 1;
        end
        4'd2: if (p_cmd == 4'd2) pm_st <= 4'd0;
        default: pm_st <= 4'd0;
      endcase
    end
  end

  assign p_status = pm_st;
  assign p_dout   = (pm_st == 4'd2) ? pm_res : pm_junk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_force(input int f);
    force_req = f;
    @(negedge clk);
    force_req = 0;
  endtask

  // Present one job and return one negedge after it has been accepted.
  task automatic send_req(input string tag, input logic [31:0] k, c1, c2, c3);
    int w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_constK = k; req_const1 = c1; req_const2 = c2; req_const3 = c3;
    @(negedge clk);
    req_valid  = 1'b0;
    req_constK = $urandom; req_const1 = $urandom;
    req_const2 = $urandom; req_const3 = $urandom;
    check({tag, "_constK_reg"}, p_constK, k);
    check({tag, "_const2_reg"}, p_const2, c2);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Wait for the response and compare against the job-level expectation.
  task automatic wait_rsp(input string tag, input logic [31:0] k, c1, c2, c3,
                          input bit hang, input int hold, input bit tie);
    int cyc = 0, first_run = -1, acks = 0, runs = 0;
    bit got = 0;
    logic [31:0] exp_d;
    exp_d = hang ? 32'd0 : pfun(k, c1, c2, c3, pm_mix);
    if (!hang) exp_jobs = (exp_jobs + 1) % (1 << CW);
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (p_cmd == 4'd1) begin
        runs++;
        if (first_run < 0) first_run = cyc;
      end
      if (p_cmd == 4'd2) acks++;
      if (p_cmd == 4'd2 && runs == 0) check({tag, "_ack_before_run"}, 32'd1, 32'd0);
      if (rsp_valid) got = 1;
    end
    check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, "_run_issued"}, 32'(runs != 0), 32'd1);
    if (hang) begin
      check({tag, "_tmo_latency"}, 32'(cyc - first_run), 32'(TMO));
      check({tag, "_no_ack"}, 32'(acks), 32'd0);
    end else begin
      check({tag, "_ack_issued"}, 32'(acks != 0), 32'd1);
    end
    check({tag, "_data"}, rsp_data, exp_d);
    check({tag, "_timeout"}, 32'(rsp_timeout), 32'(hang));
    check({tag, "_job_count"}, 32'(job_count), 32'(exp_jobs));
    check({tag, "_proc_K"}, pm_sK, k);
    check({tag, "_proc_c1"}, pm_s1, c1);
    check({tag, "_proc_c3"}, pm_s3, c3);
    $display("job %s data=0x%08h timeout=%0d job_count=%0d", tag, rsp_data,
             rsp_timeout, job_count);
    if (tie) return;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_data"}, rsp_data, exp_d);
      check({tag, "_hold_const2"}, p_const2, c2);
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic job(input string tag, input logic [31:0] k, c1, c2, c3,
                     input bit hang, input int hold, input bit tie);
    pm_hang = hang;
    send_req(tag, k, c1, c2, c3);
    wait_rsp(tag, k, c1, c2, c3, hang, hold, tie);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] k, c1, c2, c3;
    int w;
    nreset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_constK = '0; req_const1 = '0; req_const2 = '0; req_const3 = '0;
    @(negedge clk); @(negedge clk);
    check("rst_p_cmd", 32'(p_cmd), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_job_count", 32'(job_count), 32'd0);
    check("rst_constK", p_constK, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Normal job with 3-cycle backpressure.
    pm_lat = 5; pm_mix = 0;
    job("normal", 32'h10, 32'h11, 32'h22, 32'h33, 0, 3, 0);

    // Timeout, then a job that must wait for the hung processor to idle.
    job("timeout", 32'hA, 32'hB, 32'hC, 32'hD, 1, 0, 0);
    pm_hang = 0;
    send_req("after_tmo", 32'h1, 32'h2, 32'h3, 32'h4);
    for (int i = 0; i < 4; i++) begin
      check("after_tmo_load_nop", 32'(p_cmd), 32'd0);
      @(negedge clk);
    end
    do_force(2);
    wait_rsp("after_tmo", 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 0);

    // Stale COMPLETE at request time.
    do_force(1);
    send_req("stale", 32'h5, 32'h6, 32'h77, 32'h8);
    for (int i = 0; i < 4; i++) begin
      check("stale_load_nop", 32'(p_cmd), 32'd0);
      @(negedge clk);
    end
    do_force(2);
    wait_rsp("stale", 32'h5, 32'h6, 32'h77, 32'h8, 0, 1, 0);

    // Back-to-back with rsp_ready tied high.
    rsp_ready = 1'b1;
    pm_mix = 1;
    for (int j = 0; j < 3; j++) begin
      k = $urandom; c1 = $urandom; c3 = $urandom;
      c2 = 32'h100 + 32'(j);
      pm_lat = 1 + j;
      job($sformatf("b2b%0d", j), k, c1, c2, c3, 0, 0, 1);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_idle", 32'(req_ready), 32'd1);

    // Reset while waiting for COMPLETE.
    pm_lat = 30;
    send_req("rst_mid", 32'h9, 32'h9, 32'h9, 32'h9);
    w = 0;
    while (!(busy && p_cmd == 4'd0 && p_status == 4'd1) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_in_wait", 32'(w < 20), 32'd1);
    nreset = 1'b0;
    #1;
    check("rst_mid_p_cmd", 32'(p_cmd), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_job_count", 32'(job_count), 32'd0);
    check("rst_mid_constK", p_constK, 32'd0);
    exp_jobs = 0;
    @(negedge clk); @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    pm_lat = 3;
    job("post_rst", 32'h44, 32'h55, 32'h66, 32'h77, 0, 0, 0);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      bit hang;
      k = $urandom; c1 = $urandom; c2 = $urandom; c3 = $urandom;
      pm_lat = $urandom_range(1, 8);
      hang = ($urandom_range(0, 3) == 0);
      job($sformatf("rnd%0d", j), k, c1, c2, c3, hang,
          $urandom_range(0, 3), 0);
      if (hang) begin
        pm_hang = 0;
        do_force(2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

endmodule
